// File: rtl/systolic_seq_ctrl_if.sv
// systolic_seq_ctrl_if: valid/ready stream of C words with row-major index
interface systolic_seq_ctrl_if #(parameter int DW = 32);
  logic [DW-1:0] data;
  logic [3:0] idx;
  logic valid;
  logic ready;
  modport master(output data, idx, valid, input ready);
  modport slave(input data, idx, valid, output ready);
endinterface

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: clear/feed/flush/drain sequencer for the NxN systolic array; SYS_CTRL_PERF_EN adds perf_cycles
module systolic_seq_ctrl #(
  parameter int N = 4,
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW-1:0]     base_addr,
  output logic              busy,
  output logic              done,
  output logic              pe_clear,
  output logic [N-1:0]      mem_en,
  output logic [N*AW-1:0]   mem_addr,
  output logic [N-1:0]      feed_valid,
  input  logic [N*N*DW-1:0] c_flat,
`ifdef SYS_CTRL_PERF_EN
  output logic [15:0]       perf_cycles,
`endif
  systolic_seq_ctrl_if.master stream
);
  localparam int LAST_T = 2*N-2;
  localparam int FLUSH_CYC = 2*N-2+MEM_LAT;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DRAIN} state_t;
  state_t state;
  int t;
  int cnt;
  logic [AW-1:0] base;
  logic [3:0] idx;
  logic [DW-1:0] snap [N*N];
  function automatic logic [N-1:0] lane_en(input int tt);
    lane_en = '0;
    for (int i = 0; i < N; i++) lane_en[i] = tt >= i && tt < i+N;
  endfunction
  function automatic logic [N*AW-1:0] lane_addr(input int tt, input logic [AW-1:0] b);
    lane_addr = '0;
    for (int i = 0; i < N; i++) lane_addr[i*AW +: AW] = (tt >= i && tt < i+N) ? b + AW'(tt-i) : '0;
  endfunction
  assign stream.data = snap[idx];
  assign stream.idx = idx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      t <= 0;
      cnt <= 0;
      base <= '0;
      idx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pe_clear <= 1'b0;
      mem_en <= '0;
      mem_addr <= '0;
      stream.valid <= 1'b0;
      for (int k = 0; k < N*N; k++) snap[k] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          base <= base_addr;
          busy <= 1'b1;
          pe_clear <= 1'b1;
          state <= CLEAR;
        end
        CLEAR: begin
          pe_clear <= 1'b0;
          t <= 0;
          mem_en <= lane_en(0);
          mem_addr <= lane_addr(0, base);
          state <= FEED;
        end
        FEED: if (t == LAST_T) begin
          mem_en <= '0;
          mem_addr <= '0;
          cnt <= 0;
          state <= FLUSH;
        end else begin
          t <= t + 1;
          mem_en <= lane_en(t + 1);
          mem_addr <= lane_addr(t + 1, base);
        end
        FLUSH: if (cnt == FLUSH_CYC-1) begin
          for (int k = 0; k < N*N; k++) snap[k] <= c_flat[k*DW +: DW];
          idx <= '0;
          stream.valid <= 1'b1;
          state <= DRAIN;
        end else cnt <= cnt + 1;
        DRAIN: if (stream.ready) begin
          if (idx == 4'(N*N-1)) begin
            stream.valid <= 1'b0;
            busy <= 1'b0;
            done <= 1'b1;
            state <= IDLE;
          end else idx <= idx + 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  generate
    if (MEM_LAT == 0) begin : g_nolat
      assign feed_valid = mem_en;
    end else begin : g_lat
      logic [N-1:0] pipe [MEM_LAT];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) for (int k = 0; k < MEM_LAT; k++) pipe[k] <= '0;
        else begin
          pipe[0] <= mem_en;
          for (int k = 1; k < MEM_LAT; k++) pipe[k] <= pipe[k-1];
        end
      end
      assign feed_valid = pipe[MEM_LAT-1];
    end
  endgenerate
`ifdef SYS_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_cycles <= '0;
    else perf_cycles <= (state == IDLE && start) ? '0 : (busy && perf_cycles != 16'hFFFF) ? perf_cycles + 16'd1 : perf_cycles;
  end
`endif
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: scoreboard bench for feed pattern, wrap, drain, backpressure, abort and perf counter
module tb_systolic_seq_ctrl;
  localparam int N = 4;
  localparam int DW = 32;
  localparam int AW = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic busy, done, pe_clear;
  logic [N-1:0] mem_en, feed_valid;
  logic [N*AW-1:0] mem_addr;
  logic [N*N*DW-1:0] c_flat = '0;
`ifdef SYS_CTRL_PERF_EN
  logic [15:0] perf_cycles;
`endif
  systolic_seq_ctrl_if #(.DW(DW)) sif();
  systolic_seq_ctrl #(.N(N), .DW(DW), .AW(AW), .MEM_LAT(1)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .busy(busy),
    .done(done),
    .pe_clear(pe_clear),
    .mem_en(mem_en),
    .mem_addr(mem_addr),
    .feed_valid(feed_valid),
    .c_flat(c_flat),
`ifdef SYS_CTRL_PERF_EN
    .perf_cycles(perf_cycles),
`endif
    .stream(sif)
  );
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  int nbusy = 0;
  logic [DW+3:0] sb [$];
  logic [N-1:0] en_tab [7] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask
  task automatic step;
    @(negedge clk);
    if (busy) nbusy++;
  endtask
  task automatic load_c(input int mode);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        c_flat[(r*N+c)*DW +: DW] = (mode == 0) ? ((r == c) ? 32'd5 : 32'd0) : 32'($urandom);
  endtask
  task automatic run(input logic [AW-1:0] base, input int rmode, input bit spam, input bit chg);
    int stalls = 0;
    int k = 0;
    bit fin = 0;
    bit pstall = 0;
    bit rdy;
    logic [3:0] pidx;
    logic [DW-1:0] pdata;
    logic [DW+3:0] e;
    logic [AW-1:0] a;
    for (int j = 0; j < N*N; j++) sb.push_back({4'(j), c_flat[j*DW +: DW]});
    nbusy = 0;
    base_addr = base;
    start = 1'b1;
    step();
    start = 1'b0;
    base_addr = ~base;
    check("clear_pulse", pe_clear, 1);
    check("clear_busy", busy, 1);
    check("clear_en", mem_en, 0);
    for (int tt = 0; tt < 7; tt++) begin
      step();
      if (spam) begin
        start = 1'b1;
        base_addr = base + 5'd9;
      end
      check("feed_en", mem_en, en_tab[tt]);
      check("feed_fv", feed_valid, tt == 0 ? 4'h0 : en_tab[tt-1]);
      check("feed_clr", pe_clear, 0);
      for (int i = 0; i < N; i++) begin
        a = (tt >= i && tt < i+N) ? AW'(base + AW'(tt - i)) : '0;
        check($sformatf("addr_l%0d_t%0d", i, tt), mem_addr[i*AW +: AW], a);
      end
    end
    start = 1'b0;
    for (int f = 0; f < 7; f++) begin
      step();
      check("flush_en", mem_en, 0);
      check("flush_fv", feed_valid, f == 0 ? en_tab[6] : 4'h0);
      check("flush_valid", sif.valid, 0);
    end
    for (int c = 0; c < 200 && !fin; c++) begin
      step();
      if (chg) c_flat = ~c_flat;
      check("drain_valid", sif.valid, 1);
      if (pstall) begin
        check("hold_idx", sif.idx, pidx);
        check("hold_data", sif.data, pdata);
      end
      rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? (k % 3 == 0) : 1'($urandom_range(0, 1));
      k++;
      sif.ready = rdy;
      if (sif.valid && rdy) begin
        e = sb.pop_front();
        check("sb_idx", sif.idx, e[DW+3:DW]);
        check("sb_data", sif.data, e[DW-1:0]);
        pstall = 0;
        if (e[DW+3:DW] == 4'(N*N-1)) fin = 1;
      end else begin
        stalls++;
        pstall = sif.valid;
        pidx = sif.idx;
        pdata = sif.data;
      end
    end
    if (!fin) check("drain_timeout", 0, 1);
    step();
    sif.ready = 1'b0;
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_valid", sif.valid, 0);
    check("busy_cycles", 64'(nbusy), 64'(31 + stalls));
    check("sb_empty", 64'(sb.size()), 0);
`ifdef SYS_CTRL_PERF_EN
    check("perf", perf_cycles, 16'(31 + stalls));
`endif
    step();
    check("done_once", done, 0);
`ifdef SYS_CTRL_PERF_EN
    step();
    check("perf_hold", perf_cycles, 16'(31 + stalls));
`endif
  endtask
  task automatic abort_run;
    base_addr = 5'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    check("abort_t3_en", mem_en, 4'hF);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_en", mem_en, 0);
    check("abort_addr", mem_addr, 0);
    check("abort_fv", feed_valid, 0);
    check("abort_clr", pe_clear, 0);
    check("abort_valid", sif.valid, 0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      check("abort_nodone", done, 0);
      check("abort_idle", busy, 0);
    end
  endtask
  initial begin
    sif.ready = 1'b0;
    repeat (2) step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_clr", pe_clear, 0);
    check("rst_en", mem_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_fv", feed_valid, 0);
    check("rst_valid", sif.valid, 0);
    check("rst_data", sif.data, 0);
`ifdef SYS_CTRL_PERF_EN
    check("rst_perf", perf_cycles, 0);
`endif
    rst = 1'b0;
    step();
    load_c(0);
    run(5'd0, 0, 0, 0);
    run(5'd30, 0, 0, 0);
    load_c(1);
    run(5'd7, 1, 0, 1);
    load_c(1);
    run(5'd12, 2, 1, 1);
    abort_run();
    load_c(0);
    run(5'd0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
